// File: rtl/digi_marker.sv
// Command-driven marker pin: delayed set/clear/toggle or a
// delayed pulse of programmed width on one registered output.
module digi_marker #(
  parameter int CW = 64,
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cstrobe,
  input  logic [CW-1:0] command,
  output logic          mark,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    ACTIVE
  } state_t;

  localparam logic [1:0] OP_CLR = 2'd0;
  localparam logic [1:0] OP_SET = 2'd1;
  localparam logic [1:0] OP_PLS = 2'd2;
  localparam logic [1:0] OP_TGL = 2'd3;

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] w_q, w_d;
  logic [1:0]    op_q, op_d;
  logic          lvl_q, lvl_d;
  logic          mark_q, mark_d;
  logic          cmd_unused;

  // Only op, delay and width fields are decoded.
  assign cmd_unused = ^command;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      w_q     <= '0;
      op_q    <= OP_CLR;
      lvl_q   <= 1'b0;
      mark_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      op_q    <= op_d;
      lvl_q   <= lvl_d;
      mark_q  <= mark_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    op_d    = op_q;
    lvl_d   = lvl_q;
    mark_d  = mark_q;
    if (cstrobe) begin
      // A new command always restores the held level first.
      op_d    = command[1:0];
      cnt_d   = command[16 +: TW];
      w_d     = command[32 +: TW];
      mark_d  = lvl_q;
      state_d = DELAY;
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        DELAY: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - TW'(1);
          end else begin
            state_d = IDLE;
            unique case (op_q)
              OP_CLR: begin
                lvl_d  = 1'b0;
                mark_d = 1'b0;
              end
              OP_SET: begin
                lvl_d  = 1'b1;
                mark_d = 1'b1;
              end
              OP_TGL: begin
                lvl_d  = ~lvl_q;
                mark_d = ~lvl_q;
              end
              OP_PLS: begin
                if (w_q != '0) begin
                  mark_d  = ~lvl_q;
                  cnt_d   = w_q - TW'(1);
                  state_d = ACTIVE;
                end
              end
              default: begin
              end
            endcase
          end
        end
        ACTIVE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - TW'(1);
          end else begin
            mark_d  = lvl_q;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign mark = mark_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_digi_marker.sv
// Bench for digi_marker: directed steps plus random commands
// checked against an edge-indexed schedule model.
module tb_digi_marker;

  logic        clk = 1'b0;
  logic        reset;
  logic        cstrobe;
  logic [63:0] command;
  logic        mark;
  logic        busy;

  int checks = 0;
  int errors = 0;

  longint edge_n = 0;
  longint e0 = 0;
  longint m_d = 0;
  longint m_w = 0;
  int     m_op = 0;
  bit     m_act = 1'b0;
  bit     m_lvl = 1'b0;
  bit     m_mark = 1'b0;

  digi_marker #(.CW(64), .TW(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .cstrobe (cstrobe),
    .command (command),
    .mark    (mark),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk(int op, int d, int w);
    logic [63:0] c;
    c = {$urandom, $urandom};
    c[1:0]   = 2'(op);
    c[31:16] = 16'(d);
    c[47:32] = 16'(w);
    return c;
  endfunction

  task automatic check(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Action happens D+1 edges after the strobe edge; a pulse
  // ends W edges after that.
  task automatic model_edge(bit r, bit cs, logic [63:0] cmd);
    longint rel;
    if (r) begin
      m_lvl  = 1'b0;
      m_mark = 1'b0;
      m_act  = 1'b0;
    end else if (cs) begin
      m_act  = 1'b1;
      e0     = edge_n;
      m_op   = int'(cmd[1:0]);
      m_d    = longint'(cmd[31:16]);
      m_w    = longint'(cmd[47:32]);
      m_mark = m_lvl;
    end else if (m_act) begin
      rel = edge_n - e0;
      if (rel == m_d + 1) begin
        if (m_op == 0) m_lvl = 1'b0;
        if (m_op == 1) m_lvl = 1'b1;
        if (m_op == 3) m_lvl = !m_lvl;
        if (m_op != 2) begin
          m_mark = m_lvl;
          m_act  = 1'b0;
        end else if (m_w == 0) begin
          m_act = 1'b0;
        end else begin
          m_mark = !m_lvl;
        end
      end else if (m_op == 2 && rel == m_d + m_w + 1) begin
        m_mark = m_lvl;
        m_act  = 1'b0;
      end
    end
  endtask

  task automatic tick(bit r, bit cs, logic [63:0] cmd);
    reset   = r;
    cstrobe = cs;
    command = cmd;
    @(posedge clk);
    edge_n++;
    model_edge(r, cs, cmd);
    #1;
    reset   = 1'b0;
    cstrobe = 1'b0;
    command = {$urandom, $urandom};
    check("mark", mark, m_mark);
    check("busy", busy, m_act);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, command);
  endtask

  initial begin
    reset   = 1'b1;
    cstrobe = 1'b0;
    command = '0;

    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    check("rst_mark", mark, 1'b0);
    check("rst_busy", busy, 1'b0);
    idle(10);
    check("idle_mark", mark, 1'b0);

    tick(1'b0, 1'b1, mk(1, 0, 7));
    check("set_busy", busy, 1'b1);
    idle(1);
    check("set_mark", mark, 1'b1);
    check("set_done", busy, 1'b0);
    tick(1'b0, 1'b1, mk(0, 5, 0));
    idle(5);
    check("clr_wait", mark, 1'b1);
    idle(1);
    check("clr_mark", mark, 1'b0);

    tick(1'b0, 1'b1, mk(2, 3, 4));
    idle(4);
    check("pls_hi", mark, 1'b1);
    idle(3);
    check("pls_hold", mark, 1'b1);
    idle(1);
    check("pls_lo", mark, 1'b0);
    check("pls_busy", busy, 1'b0);

    tick(1'b0, 1'b1, mk(1, 0, 0));
    idle(2);
    tick(1'b0, 1'b1, mk(2, 0, 2));
    idle(1);
    check("neg_pls", mark, 1'b0);
    idle(3);
    check("neg_end", mark, 1'b1);
    tick(1'b0, 1'b1, mk(3, 0, 0));
    idle(2);
    check("tgl", mark, 1'b0);

    tick(1'b0, 1'b1, mk(2, 0, 10));
    idle(3);
    check("abort_pre", mark, 1'b1);
    tick(1'b0, 1'b1, mk(1, 2, 0));
    check("abort", mark, 1'b0);
    idle(2);
    check("abort_wait", mark, 1'b0);
    idle(1);
    check("abort_set", mark, 1'b1);
    idle(4);
    check("abort_stay", mark, 1'b1);

    tick(1'b1, 1'b1, mk(1, 0, 0));
    check("rst_prio_m", mark, 1'b0);
    check("rst_prio_b", busy, 1'b0);
    idle(3);
    check("rst_ign", mark, 1'b0);
    tick(1'b0, 1'b1, mk(2, 0, 20));
    idle(3);
    tick(1'b1, 1'b0, '0);
    check("rst_mid_m", mark, 1'b0);
    check("rst_mid_b", busy, 1'b0);
    idle(2);
    tick(1'b0, 1'b1, mk(2, 3, 0));
    idle(3);
    check("w0_busy", busy, 1'b1);
    idle(1);
    check("w0_idle", busy, 1'b0);
    check("w0_mark", mark, 1'b0);

    tick(1'b0, 1'b1, mk(1, 16'hFFFF, 0));
    idle(300);
    check("sat_busy", busy, 1'b1);
    check("sat_mark", mark, 1'b0);
    tick(1'b0, 1'b1, mk(2, 1, 16'hFFFF));
    idle(400);
    check("satw_mark", mark, 1'b1);
    tick(1'b0, 1'b1, mk(0, 0, 0));
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) begin
        tick(1'b1, $urandom_range(1) == 1, mk(1, 0, 0));
      end else if ($urandom_range(9) == 0) begin
        tick(1'b0, 1'b1, mk($urandom_range(3),
             $urandom_range(7), $urandom_range(6)));
      end else begin
        idle(1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
